irq_sequencer: RTL and testbench
================================

// Module: irq_sequencer
// PURPOSE
//  Interrupt controller and sequencer for the CPU datapath.
//  - Latches N edge-triggered interrupt requests and masks them.
//  - Picks the highest-priority pending line at an instruction boundary.
//  - Runs the two-cycle take/save handshake: irq_take loads the vector into the PC, then irq_save writes the return PC to r14.
//  - Blocks nesting until RETI. Sits between the instruction decoder/control and datapath; drives its irq_take, irq_save and irq_vector inputs.
// PARAMETERS
//  N_IRQ      8        number of interrupt lines (1..16)
//  VEC_BASE   16'h0020 byte address of vector slot 0
//  VEC_STRIDE 4        bytes between vector slots (power of two)
// PORTS
//  i_clk         in   1      clock
//  i_rst_n       in   1      reset, asynchronous, active-low
//  i_irq         in   N_IRQ  raw requests, synchronous to i_clk, rising-edge sensitive
//  i_exec_ce     in   1      instruction completes this cycle (boundary)
//  i_imm_pre     in   1      completing instruction is an imm prefix; not a legal boundary
//  i_is_reti     in   1      completing instruction is RETI (qualified by i_exec_ce)
//  i_mask_we     in   1      write enable for mask register
//  i_mask_d      in   N_IRQ  new mask (1 = line enabled)
//  o_irq_take    out  1      one-cycle pulse: datapath loads o_irq_vector into PC
//  o_irq_save    out  1      one-cycle pulse, cycle after take: r14 <= return PC
//  o_irq_vector  out  16     VEC_BASE + id*VEC_STRIDE; held from take until the next take
//  o_stall       out  1      gate exec_ce to the datapath (high in TAKE and SAVE)
//  o_in_isr      out  1      handler active, further takes blocked
//  o_active_id   out  4      id of the line being serviced
//  o_pending     out  N_IRQ  latched pending bits (debug/status)
// BEHAVIOUR
//  Reset: async on i_rst_n low; all outputs and state 0, mask = 0, FSM = IDLE.
//  Edge detect: i_irq_q <= i_irq each cycle; rise = i_irq & ~i_irq_q sets pending[k].
//  Pending[k] clears in the TAKE cycle for the selected k. Set and clear in the same cycle: set wins, so the bit stays 1.
//  Mask register: written on i_mask_we. The eligibility decision that cycle uses the old mask.
//  Eligible = pending & mask. Priority: lowest index wins. Ties are impossible by construction.
//  FSM (states are localparams in constants.vh):
//   IDLE: if |eligible & i_exec_ce & ~i_imm_pre & ~o_in_isr -> TAKE; latch id and vector.
//         Otherwise stay (mask changes or new edges are re-evaluated every cycle).
//   TAKE: o_irq_take=1, o_stall=1, pending[id] cleared -> SAVE (unconditional).
//   SAVE: o_irq_save=1, o_stall=1, o_in_isr<=1 -> ISR.
//   ISR:  pending keeps accumulating. On i_exec_ce & i_is_reti: o_in_isr<=0 -> IDLE.
//         The first new take happens at the next legal boundary, no earlier than 1 cycle after RETI.
//  Latency: eligible edge at cycle t with a boundary at t -> take at t+1, save at t+2, first handler fetch at t+3.
//  Boundary timing: an edge arriving in the boundary cycle itself is not eligible until the following boundary, because pending is registered.
//  Imm prefix: a boundary with i_imm_pre=1 is skipped; the take waits for the prefixed instruction to complete.
//  RETI and new request in the same cycle: RETI is processed first; the request stays pending.
//  i_exec_ce while o_stall=1 is a protocol violation; the bench asserts it never happens.
//  Vector arithmetic is 16-bit unsigned; the id is zero-extended and shifted by log2(VEC_STRIDE). Overflow wraps.
//  Reset mid-TAKE/SAVE: FSM returns to IDLE immediately. No partial save is retained.
// STRUCTURE
//  constants.vh: `IRQ_ST_IDLE/TAKE/SAVE/ISR (2-bit), `IRQ_IDW = 4.
//  Sub-module irq_prio_enc (combinational): eligible[N_IRQ-1:0] -> {valid, id[3:0]}, lowest index first.
//  Top level: edge-detect regs, pending and mask regs, FSM, vector register.
// TESTING
//  1. Reset: i_rst_n=0 mid-run -> every output 0 in the same cycle (async); after release, mask=0 and FSM=IDLE.
//  2. mask=8'h04, rise on i_irq[2], boundary at t -> take at t+1, vector=16'h0028, save at t+2, o_in_isr=1 at t+3.
//  3. mask=8'hFF, rises on lines 5 and 1 together -> first service id=1 (vector 16'h0024); after RETI, id=5 (vector 16'h0034).
//  4. Eligible request with a boundary where i_imm_pre=1 -> no take; take fires 1 cycle after the next boundary with i_imm_pre=0.
//  5. In ISR, rise on line 0 -> no take until RETI; RETI at t -> take at the next boundary >= t+1, pending[0] cleared then.
//  6. Re-edge on line k in its TAKE cycle -> pending[k] stays 1; mask write with value 0 in an eligible boundary cycle -> take still occurs (old mask).

Source files
------------

// File: rtl/irq_sequencer_pkg.sv
// rtl/irq_sequencer_pkg.sv - shared state encoding, id width and vector helper for irq_sequencer
package irq_sequencer_pkg;

    localparam int IRQ_IDW = 4;

    typedef enum logic [1:0] {
        IRQ_ST_IDLE = 2'd0,
        IRQ_ST_TAKE = 2'd1,
        IRQ_ST_SAVE = 2'd2,
        IRQ_ST_ISR  = 2'd3
    } irq_state_e;

    // Vector slot address; 16-bit arithmetic, wraps on overflow.
    function automatic logic [15:0] irq_vec_addr(
        input logic [15:0]         base,
        input logic [IRQ_IDW-1:0]  id,
        input int                  shift
    );
        irq_vec_addr = base + (16'(id) << shift);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-first priority encoder
module irq_prio_enc
    import irq_sequencer_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0]   i_eligible,
    output logic               o_valid,
    output logic [IRQ_IDW-1:0] o_id
);

    // Scan from the top down so the lowest set index is the last writer.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (i_eligible[k]) begin
                o_valid = 1'b1;
                o_id    = IRQ_IDW'(k);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - edge-latched, masked interrupt sequencer with take/save handshake
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int          N_IRQ      = 8,
    parameter logic [15:0] VEC_BASE   = 16'h0020,
    parameter int          VEC_STRIDE = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_IRQ-1:0]   i_irq,
    input  logic               i_exec_ce,
    input  logic               i_imm_pre,
    input  logic               i_is_reti,
    input  logic               i_mask_we,
    input  logic [N_IRQ-1:0]   i_mask_d,
    output logic               o_irq_take,
    output logic               o_irq_save,
    output logic [15:0]        o_irq_vector,
    output logic               o_stall,
    output logic               o_in_isr,
    output logic [IRQ_IDW-1:0] o_active_id,
    output logic [N_IRQ-1:0]   o_pending
);

    localparam int VEC_SHIFT = $clog2(VEC_STRIDE);

    irq_state_e state, state_nxt;

    logic [N_IRQ-1:0]   irq_q;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   mask;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   take_clr;
    logic               sel_valid;
    logic [IRQ_IDW-1:0] sel_id;
    logic               take_go;
    logic               isr_set;
    logic               isr_clr;

    assign rise     = i_irq & ~irq_q;
    assign eligible = pending & mask;

    irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .i_eligible (eligible),
        .o_valid    (sel_valid),
        .o_id       (sel_id)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IRQ_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_go   = 1'b0;
        isr_set   = 1'b0;
        isr_clr   = 1'b0;
        case (state)
            IRQ_ST_IDLE: begin
                if (sel_valid && i_exec_ce && !i_imm_pre && !o_in_isr) begin
                    state_nxt = IRQ_ST_TAKE;
                    take_go   = 1'b1;
                end
            end
            IRQ_ST_TAKE: state_nxt = IRQ_ST_SAVE;
            IRQ_ST_SAVE: begin
                state_nxt = IRQ_ST_ISR;
                isr_set   = 1'b1;
            end
            IRQ_ST_ISR: begin
                if (i_exec_ce && i_is_reti) begin
                    state_nxt = IRQ_ST_IDLE;
                    isr_clr   = 1'b1;
                end
            end
            default: state_nxt = IRQ_ST_IDLE;
        endcase
    end

    // Only the line latched at take time is cleared, and only during TAKE.
    always_comb begin
        take_clr = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            take_clr[k] = (state == IRQ_ST_TAKE) && (o_active_id == IRQ_IDW'(k));
        end
    end

    // A fresh edge in the clearing cycle wins over the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_q   <= i_irq;
            pending <= (pending & ~take_clr) | rise;
            if (i_mask_we) begin
                mask <= i_mask_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_active_id  <= '0;
            o_irq_vector <= '0;
        end else if (take_go) begin
            o_active_id  <= sel_id;
            o_irq_vector <= irq_vec_addr(VEC_BASE, sel_id, VEC_SHIFT);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_in_isr <= 1'b0;
        end else if (isr_set) begin
            o_in_isr <= 1'b1;
        end else if (isr_clr) begin
            o_in_isr <= 1'b0;
        end
    end

    assign o_irq_take = (state == IRQ_ST_TAKE);
    assign o_irq_save = (state == IRQ_ST_SAVE);
    assign o_stall    = o_irq_take | o_irq_save;
    assign o_pending  = pending;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - scoreboard bench for irq_sequencer
module tb_irq_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq;
    logic        exec_ce;
    logic        imm_pre;
    logic        is_reti;
    logic        mask_we;
    logic [7:0]  mask_d;
    logic        irq_take;
    logic        irq_save;
    logic [15:0] irq_vector;
    logic        stall;
    logic        in_isr;
    logic [3:0]  active_id;
    logic [7:0]  pending;

    irq_sequencer #(
        .N_IRQ      (8),
        .VEC_BASE   (16'h0020),
        .VEC_STRIDE (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq        (irq),
        .i_exec_ce    (exec_ce),
        .i_imm_pre    (imm_pre),
        .i_is_reti    (is_reti),
        .i_mask_we    (mask_we),
        .i_mask_d     (mask_d),
        .o_irq_take   (irq_take),
        .o_irq_save   (irq_save),
        .o_irq_vector (irq_vector),
        .o_stall      (stall),
        .o_in_isr     (in_isr),
        .o_active_id  (active_id),
        .o_pending    (pending)
    );

    typedef struct {
        logic [3:0]  id;
        logic [15:0] vec;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   last_cyc   = 0;
    int   exp_pushed = 0;
    int   takes_seen = 0;
    int   save_at    = -10;
    int   isr_at     = -10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per observed take and tracks the save/ISR follow-up.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc == save_at) begin
                checks++;
                if (!(irq_save && stall && !irq_take && !in_isr)) begin
                    errors++;
                    $display("FAIL save_cycle: save=%0b stall=%0b take=%0b in_isr=%0b expected 1 1 0 0",
                             irq_save, stall, irq_take, in_isr);
                end
            end
            if (cyc == isr_at) begin
                checks++;
                if (!(in_isr && !stall && !irq_save)) begin
                    errors++;
                    $display("FAIL isr_entry: in_isr=%0b stall=%0b save=%0b expected 1 0 0",
                             in_isr, stall, irq_save);
                end
            end
            if (irq_take) begin
                takes_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_take: id=%0d vec=%04h at cycle %0d, expected no take",
                             active_id, irq_vector, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (active_id !== e.id || irq_vector !== e.vec || cyc != e.cyc || !stall) begin
                        errors++;
                        $display("FAIL take: got id=%0d vec=%04h cyc=%0d stall=%0b expected id=%0d vec=%04h cyc=%0d stall=1",
                                 active_id, irq_vector, cyc, stall, e.id, e.vec, e.cyc);
                    end
                end
                save_at = cyc + 1;
                isr_at  = cyc + 2;
            end
        end
    end

    // Protocol: the bench must never present a boundary while the datapath is stalled.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && stall) begin
            checks++;
            if (exec_ce) begin
                errors++;
                $display("FAIL exec_ce_in_stall: exec_ce=1 expected 0");
            end
        end
    end

    task automatic drive(input logic [7:0] r, input logic ce, input logic imm, input logic reti,
                         input logic mwe, input logic [7:0] md);
        irq      = r;
        exec_ce  = ce;
        imm_pre  = imm;
        is_reti  = reti;
        mask_we  = mwe;
        mask_d   = md;
        last_cyc = cyc;
        @(negedge clk);
        irq     = '0;
        exec_ce = 1'b0;
        imm_pre = 1'b0;
        is_reti = 1'b0;
        mask_we = 1'b0;
        mask_d  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_take(input logic [3:0] id, input logic [15:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        e.cyc = last_cyc + 1;
        exp_q.push_back(e);
        exp_pushed++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_take"},   32'(irq_take),   32'h0);
        chk({tag, "_save"},   32'(irq_save),   32'h0);
        chk({tag, "_vector"}, 32'(irq_vector), 32'h0);
        chk({tag, "_stall"},  32'(stall),      32'h0);
        chk({tag, "_in_isr"}, 32'(in_isr),     32'h0);
        chk({tag, "_id"},     32'(active_id),  32'h0);
        chk({tag, "_pend"},   32'(pending),    32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        irq     = '0;
        exec_ce = 1'b0;
        imm_pre = 1'b0;
        is_reti = 1'b0;
        mask_we = 1'b0;
        mask_d  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single line 2, mask 0x04.
        drive(8'h00, 0, 0, 0, 1, 8'h04);
        drive(8'h04, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd2, 16'h0028);
        idle(3);
        #1;
        chk("t2_pend_after", 32'(pending), 32'h00);
        drive(8'h00, 1, 0, 1, 0, 8'h00);

        // Simultaneous lines 5 and 1: lowest index first.
        drive(8'h00, 0, 0, 0, 1, 8'hFF);
        drive(8'h22, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd1, 16'h0024);
        idle(3);
        #1;
        chk("t3_pend_5_left", 32'(pending), 32'h20);
        drive(8'h00, 1, 0, 1, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd5, 16'h0034);
        idle(3);
        drive(8'h00, 1, 0, 1, 0, 8'h00);

        // Imm-prefix boundary is not a take point.
        drive(8'h08, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 1, 0, 0, 8'h00);
        idle(2);
        #1;
        chk("t4_no_take_imm", 32'(takes_seen), 32'(exp_pushed));
        chk("t4_pend", 32'(pending), 32'h08);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd3, 16'h002C);
        idle(3);
        drive(8'h00, 1, 0, 1, 0, 8'h00);

        // Request during ISR waits for RETI.
        drive(8'h10, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd4, 16'h0030);
        idle(3);
        drive(8'h01, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        idle(1);
        #1;
        chk("t5_no_take_in_isr", 32'(takes_seen), 32'(exp_pushed));
        chk("t5_pend_0", 32'(pending), 32'h01);
        chk("t5_in_isr", 32'(in_isr), 32'h1);
        drive(8'h00, 1, 0, 1, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd0, 16'h0020);
        idle(1);
        #1;
        chk("t5_pend_cleared", 32'(pending), 32'h00);
        idle(2);
        drive(8'h00, 1, 0, 1, 0, 8'h00);

        // Re-edge on the line in its own TAKE cycle keeps it pending.
        drive(8'h40, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd6, 16'h0038);
        drive(8'h40, 0, 0, 0, 0, 8'h00);
        #1;
        chk("t6_set_wins", 32'(pending), 32'h40);
        idle(2);
        drive(8'h00, 1, 0, 1, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd6, 16'h0038);
        idle(3);
        drive(8'h00, 1, 0, 1, 0, 8'h00);

        // Mask cleared in the boundary cycle: old mask still decides.
        drive(8'h80, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 1, 8'h00);
        expect_take(4'd7, 16'h003C);
        idle(3);
        drive(8'h00, 1, 0, 1, 0, 8'h00);
        #1;
        chk("t6_pend_empty", 32'(pending), 32'h00);

        // Asynchronous reset in the TAKE cycle.
        drive(8'h00, 0, 0, 0, 1, 8'hFF);
        drive(8'h02, 0, 0, 0, 0, 8'h00);
        exec_ce = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_pre_take", 32'(irq_take), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        exec_ce = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(8'h01, 0, 0, 0, 0, 8'h00);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        idle(2);
        #1;
        chk("rst_mask_zero_no_take", 32'(takes_seen), 32'(exp_pushed));
        chk("rst_pend_kept", 32'(pending), 32'h01);
        drive(8'h00, 0, 0, 0, 1, 8'hFF);
        drive(8'h00, 1, 0, 0, 0, 8'h00);
        expect_take(4'd0, 16'h0020);
        idle(3);
        drive(8'h00, 1, 0, 1, 0, 8'h00);
        idle(2);
        #1;

        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("final_take_count", 32'(takes_seen), 32'(exp_pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
